// File: rtl/iomem_gpio_bank_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | iomem_gpio_bank_if                                                         |
// | Single-cycle iomem bus bundle shared by the GPIO bank and its master.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface iomem_gpio_bank_if;
    logic        iomem_valid;
    logic        iomem_ready;
    logic [3:0]  iomem_wstrb;
    logic [31:0] iomem_addr;
    logic [31:0] iomem_wdata;
    logic [31:0] iomem_rdata;

    modport master (
        output iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
        input  iomem_ready, iomem_rdata
    );

    modport slave (
        input  iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
        output iomem_ready, iomem_rdata
    );
endinterface
`default_nettype wire

// File: rtl/iomem_gpio_bank.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | iomem_gpio_bank                                                            |
// | Memory-mapped GPIO bank: OUT/DIR/IN registers, optional edge interrupts    |
// | compiled in only when GPIO_BANK_IRQ_EN is defined.                         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module iomem_gpio_bank #(
    parameter int unsigned      WIDTH     = 32,
    parameter logic [7:0]       BASE_PAGE = 8'h03,
    parameter logic [WIDTH-1:0] OUT_RESET = '0
) (
    input  wire                 clk,
    input  wire                 resetn,
    iomem_gpio_bank_if.slave    bus,
    input  wire  [WIDTH-1:0]    gpio_in,
    output logic [WIDTH-1:0]    gpio_out,
    output logic [WIDTH-1:0]    gpio_oe,
    output logic                irq
);

    localparam logic [2:0] c_off_out = 3'd0;
    localparam logic [2:0] c_off_dir = 3'd1;
    localparam logic [2:0] c_off_in  = 3'd2;

    function automatic logic [WIDTH-1:0] f_merge(
        input logic [WIDTH-1:0] old_v,
        input logic [WIDTH-1:0] new_v,
        input logic [WIDTH-1:0] mask
    );
        return (old_v & ~mask) | (new_v & mask);
    endfunction

    logic             w_sel;
    logic             w_wr;
    logic [2:0]       w_off;
    logic [WIDTH-1:0] w_wmask;
    logic [WIDTH-1:0] w_wdata;
    logic [WIDTH-1:0] w_rd;
    logic             w_unused;

    logic             ready_q;
    logic [31:0]      rdata_q;
    logic [WIDTH-1:0] out_q, out_d;
    logic [WIDTH-1:0] dir_q, dir_d;
    logic [WIDTH-1:0] sync1_q, sync2_q;

    // Blocking on ready_q guarantees the completion pulse never repeats back-to-back.
    assign w_sel   = bus.iomem_valid && !ready_q && (bus.iomem_addr[31:24] == BASE_PAGE);
    assign w_wr    = w_sel && (bus.iomem_wstrb != 4'b0000);
    assign w_off   = bus.iomem_addr[4:2];
    assign w_wdata = bus.iomem_wdata[WIDTH-1:0];
    assign w_unused = ^{bus.iomem_addr[23:5], bus.iomem_addr[1:0], bus.iomem_wdata};

    for (genvar i = 0; i < WIDTH; i++) begin : g_wmask
        assign w_wmask[i] = bus.iomem_wstrb[i/8];
    end

    assign out_d = (w_wr && (w_off == c_off_out)) ? f_merge(out_q, w_wdata, w_wmask) : out_q;
    assign dir_d = (w_wr && (w_off == c_off_dir)) ? f_merge(dir_q, w_wdata, w_wmask) : dir_q;

`ifdef GPIO_BANK_IRQ_EN
    localparam logic [2:0] c_off_en   = 3'd3;
    localparam logic [2:0] c_off_rise = 3'd4;
    localparam logic [2:0] c_off_stat = 3'd5;

    logic [WIDTH-1:0] en_q, rise_q, stat_q, stat_d, prev_q;
    logic [WIDTH-1:0] w_edge, w_clr;
    logic [1:0]       arm_q;
    logic             irq_q;

    // Edges are ignored until both sync stages and prev_q hold real pin samples.
    assign w_edge = (arm_q == 2'd3)
                  ? ((sync2_q & ~prev_q & rise_q) | (~sync2_q & prev_q & ~rise_q))
                  : '0;
    assign w_clr  = (w_wr && (w_off == c_off_stat)) ? (w_wdata & w_wmask) : '0;
    assign stat_d = (stat_q & ~w_clr) | w_edge;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            en_q   <= '0;
            rise_q <= '1;
            stat_q <= '0;
            prev_q <= '0;
            arm_q  <= 2'd0;
            irq_q  <= 1'b0;
        end else begin
            prev_q <= sync2_q;
            if (arm_q != 2'd3) begin
                arm_q <= arm_q + 2'd1;
            end
            stat_q <= stat_d;
            irq_q  <= |(stat_q & en_q);
            if (w_wr && (w_off == c_off_en)) begin
                en_q <= f_merge(en_q, w_wdata, w_wmask);
            end
            if (w_wr && (w_off == c_off_rise)) begin
                rise_q <= f_merge(rise_q, w_wdata, w_wmask);
            end
        end
    end

    assign irq = irq_q;
`else
    assign irq = 1'b0;
`endif

    // Reads see register contents before any same-edge write or clear.
    always_comb begin
        w_rd = '0;
        case (w_off)
            c_off_out:  w_rd = out_q;
            c_off_dir:  w_rd = dir_q;
            c_off_in:   w_rd = sync2_q;
`ifdef GPIO_BANK_IRQ_EN
            c_off_en:   w_rd = en_q;
            c_off_rise: w_rd = rise_q;
            c_off_stat: w_rd = stat_q;
`endif
            default:    w_rd = '0;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ready_q <= 1'b0;
            rdata_q <= '0;
            out_q   <= OUT_RESET;
            dir_q   <= '0;
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            ready_q <= w_sel;
            sync1_q <= gpio_in;
            sync2_q <= sync1_q;
            out_q   <= out_d;
            dir_q   <= dir_d;
            if (w_sel) begin
                rdata_q <= 32'(w_rd);
            end
        end
    end

    assign bus.iomem_ready = ready_q;
    assign bus.iomem_rdata = rdata_q;
    assign gpio_out        = out_q;
    assign gpio_oe         = dir_q;

endmodule
`default_nettype wire

// File: tb/tb_iomem_gpio_bank.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_iomem_gpio_bank                                                         |
// | Drives a 32-bit and a 12-bit bank with identical bus traffic and compares  |
// | both against a behavioural register-map model.                             |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_iomem_gpio_bank;

`ifdef GPIO_BANK_IRQ_EN
    localparam bit c_irq = 1'b1;
`else
    localparam bit c_irq = 1'b0;
`endif

    typedef struct packed {
        logic        wr;
        logic [2:0]  off;
        logic [3:0]  strb;
        logic [31:0] wdata;
        logic [31:0] rd32;
        logic [31:0] rd12;
        logic [31:0] out32;
        logic [31:0] out12;
        logic [31:0] oe32;
        logic [31:0] oe12;
    } vec_t;

    logic        clk = 1'b0;
    logic        resetn;
    logic        valid;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] pins;
    logic [31:0] out32, oe32;
    logic [11:0] out12, oe12;
    logic        irq32, irq12;
    logic        chk_on;
    int          n_chk = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    iomem_gpio_bank_if bus32();
    iomem_gpio_bank_if bus12();

    assign bus32.iomem_valid = valid;
    assign bus32.iomem_wstrb = wstrb;
    assign bus32.iomem_addr  = addr;
    assign bus32.iomem_wdata = wdata;
    assign bus12.iomem_valid = valid;
    assign bus12.iomem_wstrb = wstrb;
    assign bus12.iomem_addr  = addr;
    assign bus12.iomem_wdata = wdata;

    iomem_gpio_bank #(.WIDTH(32), .BASE_PAGE(8'h03), .OUT_RESET(32'h0)) u_dut32 (
        .clk(clk), .resetn(resetn), .bus(bus32.slave),
        .gpio_in(pins), .gpio_out(out32), .gpio_oe(oe32), .irq(irq32)
    );

    iomem_gpio_bank #(.WIDTH(12), .BASE_PAGE(8'h03), .OUT_RESET(12'hA5A)) u_dut12 (
        .clk(clk), .resetn(resetn), .bus(bus12.slave),
        .gpio_in(pins[11:0]), .gpio_out(out12), .gpio_oe(oe12), .irq(irq12)
    );

    // ---------------- behavioural model (index 0: WIDTH 32, index 1: WIDTH 12)
    logic        m_ready;
    logic [31:0] m_rdata[2], m_out[2], m_dir[2], m_en[2], m_rise[2], m_stat[2];
    logic        m_irq[2];
    logic [31:0] hist[3];
    int          since;
    logic        m_sel, m_wr;
    logic [2:0]  m_off;
    logic [31:0] m_lane, m_in;
    logic [31:0] m_set[2], m_clr[2];

    function automatic logic [31:0] f_mask(input int d);
        return (d == 0) ? 32'hFFFF_FFFF : 32'h0000_0FFF;
    endfunction

    function automatic logic [31:0] f_read(input int d, input logic [2:0] off, input logic [31:0] inval);
        case (off)
            3'd0: return m_out[d];
            3'd1: return m_dir[d];
            3'd2: return inval & f_mask(d);
            3'd3: return c_irq ? m_en[d] : 32'h0;
            3'd4: return c_irq ? m_rise[d] : 32'h0;
            3'd5: return c_irq ? m_stat[d] : 32'h0;
            default: return 32'h0;
        endcase
    endfunction

    always_comb begin
        m_sel  = valid && !m_ready && (addr[31:24] == 8'h03);
        m_wr   = m_sel && (wstrb != 4'b0000);
        m_off  = addr[4:2];
        m_lane = {{8{wstrb[3]}}, {8{wstrb[2]}}, {8{wstrb[1]}}, {8{wstrb[0]}}};
        // IN shows the pin as sampled two edges ago; zero until two samples exist.
        m_in   = (since >= 2) ? hist[1] : 32'h0;
        for (int d = 0; d < 2; d++) begin
            m_set[d] = 32'h0;
            m_clr[d] = 32'h0;
            if (c_irq && since >= 3) begin
                m_set[d] = ((hist[1] & ~hist[2] & m_rise[d]) |
                            (~hist[1] & hist[2] & ~m_rise[d])) & f_mask(d);
            end
            if (m_wr && m_off == 3'd5) begin
                m_clr[d] = wdata & m_lane & f_mask(d);
            end
        end
    end

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_ready <= 1'b0;
            since   <= 0;
            for (int k = 0; k < 3; k++) hist[k] <= 32'h0;
            for (int d = 0; d < 2; d++) begin
                m_rdata[d] <= 32'h0;
                m_out[d]   <= (d == 0) ? 32'h0 : 32'h0000_0A5A;
                m_dir[d]   <= 32'h0;
                m_en[d]    <= 32'h0;
                m_rise[d]  <= f_mask(d);
                m_stat[d]  <= 32'h0;
                m_irq[d]   <= 1'b0;
            end
        end else begin
            m_ready <= m_sel;
            since   <= (since < 3) ? since + 1 : since;
            hist[0] <= pins;
            hist[1] <= hist[0];
            hist[2] <= hist[1];
            for (int d = 0; d < 2; d++) begin
                if (m_sel) m_rdata[d] <= f_read(d, m_off, m_in);
                if (m_wr) begin
                    case (m_off)
                        3'd0: m_out[d]  <= (m_out[d] & ~m_lane) | (wdata & m_lane & f_mask(d));
                        3'd1: m_dir[d]  <= (m_dir[d] & ~m_lane) | (wdata & m_lane & f_mask(d));
                        3'd3: if (c_irq) m_en[d]   <= (m_en[d] & ~m_lane) | (wdata & m_lane & f_mask(d));
                        3'd4: if (c_irq) m_rise[d] <= (m_rise[d] & ~m_lane) | (wdata & m_lane & f_mask(d));
                        default: ;
                    endcase
                end
                if (c_irq) begin
                    m_stat[d] <= (m_stat[d] & ~m_clr[d]) | m_set[d];
                    m_irq[d]  <= |(m_stat[d] & m_en[d]);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            check("mdl_ready32", {31'b0, bus32.iomem_ready}, {31'b0, m_ready});
            check("mdl_ready12", {31'b0, bus12.iomem_ready}, {31'b0, m_ready});
            check("mdl_rdata32", bus32.iomem_rdata, m_rdata[0]);
            check("mdl_rdata12", bus12.iomem_rdata, m_rdata[1]);
            check("mdl_out32", out32, m_out[0]);
            check("mdl_out12", {20'h0, out12}, m_out[1]);
            check("mdl_oe32", oe32, m_dir[0]);
            check("mdl_oe12", {20'h0, oe12}, m_dir[1]);
            check("mdl_irq32", {31'b0, irq32}, {31'b0, m_irq[0]});
            check("mdl_irq12", {31'b0, irq12}, {31'b0, m_irq[1]});
        end
    end

    task automatic do_op(input logic [7:0] page, input logic [2:0] off, input logic [3:0] strb,
                         input logic [31:0] wd, output logic rdy, output logic [31:0] r32,
                         output logic [31:0] r12);
        @(negedge clk);
        valid = 1'b1;
        addr  = {page, 19'h0, off, 2'b00};
        wstrb = strb;
        wdata = wd;
        @(posedge clk);
        #1;
        valid = 1'b0;
        wstrb = 4'h0;
        @(negedge clk);
        rdy = bus32.iomem_ready;
        r32 = bus32.iomem_rdata;
        r12 = bus12.iomem_rdata;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        tbl [14];
        logic        rdy;
        logic [31:0] r32, r12;

        tbl[0]  = '{1'b1, 3'd0, 4'h1, 32'h0000_00A5, 32'h0, 32'h0, 32'h0000_00A5, 32'h0AA5, 32'h0, 32'h0};
        tbl[1]  = '{1'b0, 3'd0, 4'h0, 32'h0, 32'h0000_00A5, 32'h0000_0AA5, 32'h0000_00A5, 32'h0AA5, 32'h0, 32'h0};
        tbl[2]  = '{1'b1, 3'd1, 4'hF, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0000_00A5, 32'h0AA5, 32'hFFFF_FFFF, 32'h0FFF};
        tbl[3]  = '{1'b0, 3'd1, 4'h0, 32'h0, 32'hFFFF_FFFF, 32'h0000_0FFF, 32'h0000_00A5, 32'h0AA5, 32'hFFFF_FFFF, 32'h0FFF};
        tbl[4]  = '{1'b1, 3'd0, 4'hA, 32'h1234_5678, 32'h0, 32'h0, 32'h1200_56A5, 32'h06A5, 32'hFFFF_FFFF, 32'h0FFF};
        tbl[5]  = '{1'b0, 3'd0, 4'h0, 32'h0, 32'h1200_56A5, 32'h0000_06A5, 32'h1200_56A5, 32'h06A5, 32'hFFFF_FFFF, 32'h0FFF};
        tbl[6]  = '{1'b1, 3'd6, 4'hF, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h1200_56A5, 32'h06A5, 32'hFFFF_FFFF, 32'h0FFF};
        tbl[7]  = '{1'b0, 3'd6, 4'h0, 32'h0, 32'h0, 32'h0, 32'h1200_56A5, 32'h06A5, 32'hFFFF_FFFF, 32'h0FFF};
        tbl[8]  = '{1'b0, 3'd7, 4'h0, 32'h0, 32'h0, 32'h0, 32'h1200_56A5, 32'h06A5, 32'hFFFF_FFFF, 32'h0FFF};
        tbl[9]  = '{1'b1, 3'd1, 4'h4, 32'h0, 32'h0, 32'h0, 32'h1200_56A5, 32'h06A5, 32'hFF00_FFFF, 32'h0FFF};
        tbl[10] = '{1'b0, 3'd1, 4'h0, 32'h0, 32'hFF00_FFFF, 32'h0000_0FFF, 32'h1200_56A5, 32'h06A5, 32'hFF00_FFFF, 32'h0FFF};
`ifdef GPIO_BANK_IRQ_EN
        tbl[11] = '{1'b0, 3'd4, 4'h0, 32'h0, 32'hFFFF_FFFF, 32'h0000_0FFF, 32'h1200_56A5, 32'h06A5, 32'hFF00_FFFF, 32'h0FFF};
`else
        tbl[11] = '{1'b0, 3'd4, 4'h0, 32'h0, 32'h0, 32'h0, 32'h1200_56A5, 32'h06A5, 32'hFF00_FFFF, 32'h0FFF};
`endif
        tbl[12] = '{1'b0, 3'd3, 4'h0, 32'h0, 32'h0, 32'h0, 32'h1200_56A5, 32'h06A5, 32'hFF00_FFFF, 32'h0FFF};
        tbl[13] = '{1'b1, 3'd0, 4'hF, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'hFF00_FFFF, 32'h0FFF};

        chk_on = 1'b0;
        resetn = 1'b0;
        valid  = 1'b0;
        wstrb  = 4'h0;
        addr   = 32'h0;
        wdata  = 32'h0;
        pins   = 32'h0;
        repeat (3) @(negedge clk);
        chk_on = 1'b1;

        check("rst_ready", {31'b0, bus32.iomem_ready}, 32'h0);
        check("rst_rdata", bus32.iomem_rdata, 32'h0);
        check("rst_out32", out32, 32'h0);
        check("rst_out12", {20'h0, out12}, 32'h0000_0A5A);
        check("rst_oe32", oe32, 32'h0);
        check("rst_irq", {31'b0, irq32}, 32'h0);
        resetn = 1'b1;

        for (int i = 0; i < 14; i++) begin
            do_op(8'h03, tbl[i].off, tbl[i].strb, tbl[i].wdata, rdy, r32, r12);
            check($sformatf("tbl%0d_ready", i), {31'b0, rdy}, 32'h1);
            if (!tbl[i].wr) begin
                check($sformatf("tbl%0d_rd32", i), r32, tbl[i].rd32);
                check($sformatf("tbl%0d_rd12", i), r12, tbl[i].rd12);
            end
            check($sformatf("tbl%0d_out32", i), out32, tbl[i].out32);
            check($sformatf("tbl%0d_out12", i), {20'h0, out12}, tbl[i].out12);
            check($sformatf("tbl%0d_oe32", i), oe32, tbl[i].oe32);
            check($sformatf("tbl%0d_oe12", i), {20'h0, oe12}, tbl[i].oe12);
        end

        // Valid held four cycles on the decoded page: ready alternates 0,1,0,1.
        @(negedge clk);
        valid = 1'b1;
        addr  = {8'h03, 19'h0, 3'd2, 2'b00};
        wstrb = 4'h0;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            check($sformatf("hold_ready%0d", i), {31'b0, bus32.iomem_ready}, (i % 2 == 1) ? 32'h1 : 32'h0);
        end
        valid = 1'b0;

        @(negedge clk);
        valid = 1'b1;
        addr  = {8'h04, 19'h0, 3'd0, 2'b00};
        wstrb = 4'hF;
        wdata = 32'hFFFF_FFFF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("page4_ready%0d", i), {31'b0, bus32.iomem_ready}, 32'h0);
        end
        valid = 1'b0;
        wstrb = 4'h0;
        check("page4_out32", out32, 32'h0);

`ifdef GPIO_BANK_IRQ_EN
        do_op(8'h03, 3'd3, 4'hF, 32'h8, rdy, r32, r12);
        do_op(8'h03, 3'd4, 4'hF, 32'h8, rdy, r32, r12);
        pins[3] = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            check($sformatf("irq_rise_c%0d", k), {31'b0, irq32}, (k == 4) ? 32'h1 : 32'h0);
        end
        do_op(8'h03, 3'd5, 4'h0, 32'h0, rdy, r32, r12);
        check("stat_set32", r32, 32'h8);
        check("stat_set12", r12, 32'h8);
        do_op(8'h03, 3'd5, 4'hF, 32'h8, rdy, r32, r12);
        @(negedge clk);
        check("irq_cleared", {31'b0, irq32}, 32'h0);
        do_op(8'h03, 3'd5, 4'h0, 32'h0, rdy, r32, r12);
        check("stat_cleared", r32, 32'h0);

        do_op(8'h03, 3'd4, 4'hF, 32'h9, rdy, r32, r12);
        pins[0] = 1'b1;
        @(negedge clk);
        do_op(8'h03, 3'd5, 4'hF, 32'h1, rdy, r32, r12);
        do_op(8'h03, 3'd5, 4'h0, 32'h0, rdy, r32, r12);
        check("set_beats_clr32", r32, 32'h1);
        check("set_beats_clr12", r12, 32'h1);
`endif

        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            valid = ($urandom_range(0, 3) != 0);
            addr  = {($urandom_range(0, 7) == 0) ? 8'h04 : 8'h03, 19'($urandom),
                     3'($urandom_range(0, 7)), 2'($urandom)};
            wstrb = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
            wdata = $urandom;
            pins  = pins ^ ($urandom & $urandom & $urandom & $urandom);
        end
        @(negedge clk);
        valid = 1'b0;
        wstrb = 4'h0;

        // Reset lands while an OUT write is pending; pins are high across release.
        pins = 32'hFFFF_FFFF;
        do_op(8'h03, 3'd0, 4'hF, 32'hFFFF_FFFF, rdy, r32, r12);
        check("pre_rst_out32", out32, 32'hFFFF_FFFF);
        @(negedge clk);
        valid = 1'b1;
        addr  = {8'h03, 19'h0, 3'd0, 2'b00};
        wstrb = 4'hF;
        wdata = 32'h0000_1111;
        #2 resetn = 1'b0;
        @(posedge clk);
        #1;
        valid = 1'b0;
        wstrb = 4'h0;
        @(negedge clk);
        check("abort_ready", {31'b0, bus32.iomem_ready}, 32'h0);
        check("abort_out32", out32, 32'h0);
        check("abort_out12", {20'h0, out12}, 32'h0000_0A5A);
        check("abort_irq", {31'b0, irq32}, 32'h0);
        resetn = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check($sformatf("post_rst_ready%0d", i), {31'b0, bus32.iomem_ready}, 32'h0);
        end
        repeat (4) @(negedge clk);
        do_op(8'h03, 3'd5, 4'h0, 32'h0, rdy, r32, r12);
        check("no_edge_at_release32", r32, 32'h0);
        check("no_edge_at_release12", r12, 32'h0);
        do_op(8'h03, 3'd2, 4'h0, 32'h0, rdy, r32, r12);
        check("in_after_release32", r32, 32'hFFFF_FFFF);
        check("in_after_release12", r12, 32'h0000_0FFF);

        @(negedge clk);
        chk_on = 1'b0;
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
`default_nettype wire
